// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave front-end that receives a CMD_W+DATA_W bit command word
// and shifts out a DATA_W bit read response after a tx_valid handshake.
//   clk, rst       : clock, asynchronous active-high reset
//   ss_n, mosi     : active-low select, serial input (MSB first)
//   tx_valid/data  : read response handshake, honoured only while waiting for it
//   miso           : serial output (MSB first), 0 when not shifting
//   rx_data/valid  : last complete word and its one-cycle strobe
//   busy           : state is not IDLE
//   frame_err      : one-cycle strobe after an aborted frame; only generated when
//                    SPI_SLAVE_PARAM_FRAME_ERR_EN is defined, otherwise tied to 0
module spi_slave_param #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ss_n,
    input  logic                      mosi,
    input  logic                      tx_valid,
    input  logic [DATA_W-1:0]         tx_data,
    output logic                      miso,
    output logic [CMD_W+DATA_W-1:0]   rx_data,
    output logic                      rx_valid,
    output logic                      busy,
    output logic                      frame_err
);
    localparam int N  = CMD_W + DATA_W;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_TX   = CW'(DATA_W);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-2:0]       sr_q, sr_d;
    logic [N-1:0]       rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
    logic               miso_q, miso_d;
    logic               rd_seen_q, rd_seen_d;
    logic [N-1:0]       shift;

    // The N-1 bit holding register plus the live mosi bit form the full word.
    assign shift = {sr_q, mosi};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_sr_d    = tx_sr_q;
        miso_d     = 1'b0;
        rd_seen_d  = rd_seen_q;
        // Deselect wins over everything else, so an aborted frame never commits.
        if (state_q != IDLE && ss_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (!ss_n) begin
                    state_d = CHK_CMD;
                    cnt_d   = '0;
                end
                CHK_CMD: begin
                    sr_d    = shift[N-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    state_d = !mosi ? WRITE : (rd_seen_q ? READ_DATA : READ_ADD);
                end
                WRITE, READ_ADD, READ_DATA: begin
                    sr_d  = shift[N-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d  = shift;
                        rx_valid_d = 1'b1;
                        state_d    = (state_q == READ_DATA) ? TX_WAIT : DONE;
                        rd_seen_d  = rd_seen_q | (state_q == READ_ADD);
                    end
                end
                TX_WAIT: if (tx_valid) begin
                    miso_d  = tx_data[DATA_W-1];
                    tx_sr_d = tx_data << 1;
                    cnt_d   = CW'(1);
                    state_d = TX_SHIFT;
                end
                TX_SHIFT: begin
                    // cnt_q counts bits already presented on miso.
                    if (cnt_q == CNT_TX) begin
                        state_d   = DONE;
                        rd_seen_d = 1'b0;
                    end else begin
                        miso_d  = tx_sr_q[DATA_W-1];
                        tx_sr_d = tx_sr_q << 1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // DONE has completed its work, so deselecting there is a normal end of frame.
    assign frame_err_d = ss_n && state_q != IDLE && state_q != DONE;
    assign frame_err   = frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_d;
    end
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_sr_q    <= '0;
            miso_q     <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_sr_q    <= tx_sr_d;
            miso_q     <= miso_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = state_q != IDLE;
endmodule
